gpio_ctrl_intr_bank_csr: RTL

Parametrised interrupt register block for the GPIO controller, successor to the single-register interrupt status CSR. It holds per-bank sticky interrupt status plus enable, masked-status, software-set and mode registers behind an address-decoded APB slave. It supports byte strobes, one-wait-state handshaking and error responses. It sits between the per-bank edge detectors and the SoC interrupt controller, and drives per-bank and aggregate interrupt lines.

---
 rtl/gpio_ctrl_intr_bank_csr_if.sv | 29 ++
 rtl/gpio_ctrl_intr_bank_csr.sv | 127 ++++++++++++
 2 files changed

// File: rtl/gpio_ctrl_intr_bank_csr_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | gpio_ctrl_intr_bank_csr_if : APB bus bundle for the GPIO irq CSR |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface gpio_ctrl_intr_bank_csr_if #(
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  pwrite;
  logic                  psel;
  logic                  penable;
  logic [3:0]            pstrb;
  logic [31:0]           pwdata;
  logic [31:0]           prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output paddr, pwrite, psel, penable, pstrb, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, pwrite, psel, penable, pstrb, pwdata,
    output prdata, pready, pslverr
  );
endinterface
`default_nettype wire

// File: rtl/gpio_ctrl_intr_bank_csr.sv
`default_nettype none
// +------------------------------------------------------------------+
// | gpio_ctrl_intr_bank_csr : per-bank interrupt status/enable CSRs  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module gpio_ctrl_intr_bank_csr #(
  parameter int NUM_BANKS  = 4,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  gpio_ctrl_intr_bank_csr_if.slave  apb,
  input  logic [NUM_BANKS-1:0]      edge_detected,
  input  logic [NUM_BANKS-1:0]      level_in,
  output logic [NUM_BANKS-1:0]      interrupt,
  output logic                      irq_any
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam logic [IDX_W-1:0] IDX_STATUS = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ENABLE = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_MASKED = IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_SET    = IDX_W'(3);
  localparam logic [IDX_W-1:0] IDX_MODE   = IDX_W'(4);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_BANKS-1:0]   status_q, status_d;
  logic [NUM_BANKS-1:0]   enable_q, enable_d;
  logic [NUM_BANKS-1:0]   mode_q, mode_d;
  logic [31:0]            prdata_q, prdata_d;
  logic                   pslverr_q, pslverr_d;
  logic                   irq_any_q, irq_any_d;

  logic [IDX_W-1:0]       idx;
  logic                   access;
  logic                   err;
  logic                   wr_en;
  logic [NUM_BANKS-1:0]   lane_mask;
  logic [NUM_BANKS-1:0]   wdata_masked;
  logic [NUM_BANKS-1:0]   w1c_clr;
  logic [NUM_BANKS-1:0]   sw_set;
  logic [31:0]            rdata;
  logic                   unused_apb_bits;

  assign unused_apb_bits = ^{apb.paddr[1:0], apb.pwdata};

  always_comb begin
    idx          = apb.paddr[ADDR_WIDTH-1:2];
    access       = apb.psel & apb.penable & (state_q == ST_IDLE);
    err          = (idx > IDX_MODE) |
                   (apb.pwrite & ((idx == IDX_MASKED) | (apb.pstrb == 4'h0)));
    wr_en        = access & apb.pwrite & ~err;
    lane_mask    = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      lane_mask[i] = apb.pstrb[i>>3];
    end
    wdata_masked = apb.pwdata[NUM_BANKS-1:0] & lane_mask;

    w1c_clr  = (wr_en && idx == IDX_STATUS) ? wdata_masked : '0;
    sw_set   = (wr_en && idx == IDX_SET)    ? wdata_masked : '0;
    enable_d = enable_q;
    mode_d   = mode_q;
    if (wr_en && idx == IDX_ENABLE) begin
      enable_d = (enable_q & ~lane_mask) | wdata_masked;
    end
    if (wr_en && idx == IDX_MODE) begin
      mode_d = (mode_q & ~lane_mask) | wdata_masked;
    end

    // Current mode selects the update rule; set beats a same-cycle W1C.
    status_d = (mode_q & level_in) |
               (~mode_q & ((status_q & ~w1c_clr) | edge_detected | sw_set));

    rdata = '0;
    case (idx)
      IDX_STATUS: rdata[NUM_BANKS-1:0] = status_q;
      IDX_ENABLE: rdata[NUM_BANKS-1:0] = enable_q;
      IDX_MASKED: rdata[NUM_BANKS-1:0] = status_q & enable_q;
      IDX_MODE:   rdata[NUM_BANKS-1:0] = mode_q;
      default:    rdata = '0;
    endcase

    prdata_d  = (access & ~apb.pwrite & ~err) ? rdata : 32'h0;
    pslverr_d = access & err;
    irq_any_d = |interrupt;

    state_d = state_q;
    case (state_q)
      ST_IDLE: if (access) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      status_q  <= '0;
      enable_q  <= '0;
      mode_q    <= '0;
      prdata_q  <= 32'h0;
      pslverr_q <= 1'b0;
      irq_any_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      status_q  <= status_d;
      enable_q  <= enable_d;
      mode_q    <= mode_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
      irq_any_q <= irq_any_d;
    end
  end

  assign interrupt   = status_q & enable_q;
  assign irq_any     = irq_any_q;
  assign apb.pready  = (state_q == ST_RESP);
  assign apb.prdata  = prdata_q;
  assign apb.pslverr = pslverr_q;

endmodule
`default_nettype wire
